mul_share_arbiter: RTL and testbench
====================================

# mul_share_arbiter

Shares one N-bit × N-bit shift-and-add multiplier among four requesters. A round-robin arbiter grants one requester at a time and the operands are latched. The product is computed through the shared combinational multiplier and registered. The result is then returned on a single response channel, tagged with the requester ID. The block sits between the four operand sources and the downstream consumer, and replaces per-requester multiplier copies.

## Interface
- N, default 4: operand width in bits; product width is 2N.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  4  per-requester operand-valid; bit i belongs to requester i.
- req_ready  out  4  per-requester accept strobe; one-hot or zero.
- req_a  in  4N  operand A, packed; requester i uses bits [i*N +: N].
- req_b  in  4N  operand B, packed like req_a.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  downstream can take the response.
- rsp_id  out  2  index of the requester that produced this response.
- rsp_prod  out  2N  product a*b, unsigned, full width with no truncation.
- busy  out  1  high whenever the state is not IDLE.
- op_count  out  8  count of completed responses; wraps from 255 to 0.

## Operation
- The block has three states.
  - IDLE: the arbiter is active.
  - MUL: the product is computed.
  - RESP: the block holds the response until the consumer takes it.
- Arbitration in IDLE:
  - Search req_valid starting at index ptr, ascending modulo 4.
  - The first set bit is the grant g.
  - req_ready[g] = 1 combinationally; all other bits are 0.
  - If req_valid == 0, req_ready = 0 and the state stays IDLE.
- Accept: on the edge where req_valid[g] & req_ready[g] holds:
  - latch a_q = req_a slice g;
  - latch b_q = req_b slice g;
  - latch id_q = g;
  - set ptr ← (g+1) mod 4;
  - go to MUL.
- MUL: the shared multiplier computes from a_q and b_q only. Requester inputs are ignored.
  - The product is the sum of (a_q << k) for each k where b_q[k] = 1, for k = 0..N-1, computed at 2N-bit width.
  - On the next edge, prod_q ← product and the state goes to RESP.
- RESP: rsp_valid = 1, rsp_prod = prod_q, rsp_id = id_q.
  - These outputs hold stable until rsp_ready = 1.
  - On the edge where rsp_valid & rsp_ready holds: go to IDLE and increment op_count by 1, modulo 256.
- In MUL and RESP, req_ready = 0 regardless of req_valid.
- A requester may drop req_valid before it is granted. Nothing is latched for it, and the search simply skips it.
- Operand changes after accept have no effect on the in-flight result.
- ptr advances only on accept and never on idle cycles. A lone persistent requester is therefore granted every round.

## Timing
- Reset (rst_n low, asynchronous) forces:
  - state IDLE;
  - ptr = 0;
  - a_q, b_q, id_q, prod_q = 0;
  - op_count = 0.
- Outputs during reset: rsp_valid = 0, rsp_id = 0, rsp_prod = 0, busy = 0, and req_ready is 0 while rst_n is low. Deassertion takes effect on the next edge.
- Reset mid-operation (MUL or RESP) discards the in-flight operation with no response. The next grant starts from requester 0.
- Latency: accept at edge E0, state MUL after E0, prod_q loaded and rsp_valid = 1 after E1.
  - With rsp_ready held high, the response completes at E2.
  - IDLE is re-entered after E2, and the earliest next accept is at E3.
  - Peak throughput is one operation every 3 cycles.
- Backpressure: rsp_ready low holds RESP indefinitely. op_count does not change.
- Simultaneous events:
  - All four req_valid high with ptr = 2 gives grant order 2, 3, 0, 1.
  - rsp_ready high on the cycle rsp_valid rises completes at that same edge.
- busy is high after E0 through E2 inclusive, and low again after E2.

## Test plan
- Reset, then a single request:
  - Stimulus: req_valid = 0001, a = 4'hF, b = 4'hF, rsp_ready = 1.
  - Required response: req_ready = 0001 for one cycle; rsp_valid high exactly one cycle, 2 cycles after accept; rsp_prod = 8'hE1, rsp_id = 0; op_count = 1.
- All four requesters held valid, with operands a = i+1, b = 3:
  - Grant order 0, 1, 2, 3, then 0 again.
  - Products 3, 6, 9, 12 with matching rsp_id.
  - Exactly one req_ready bit high at any time.
- Backpressure:
  - Stimulus: rsp_ready = 0 for 10 cycles during RESP (a = 5, b = 6).
  - Required response: rsp_prod stays 30 and rsp_id is constant; req_ready = 0000 throughout; completion on the first rsp_ready = 1 edge.
- Operand change after accept:
  - Stimulus: accept a = 7, b = 9, then change req_a/req_b to 0 in MUL.
  - Required response: rsp_prod = 63.
- Reset asserted in RESP:
  - Required response: rsp_valid drops immediately (asynchronously) and op_count = 0.
  - After release with req_valid = 1100, the first grant is requester 2.
- op_count wrap:
  - Stimulus: 256 completed operations.
  - Required response: op_count returns to 0.
  - Edge operands: a = 0 or b = 0 gives product 0; a = b = 4'h8 gives 8'h40.

Source files
------------

// File: rtl/mul_share_arbiter.sv
// Four-requester front end for one shared unsigned N x N multiplier.
// Round-robin grant, latched operands, registered product, tagged single response channel.
module mul_share_arbiter #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [3:0]     req_valid,
    output logic [3:0]     req_ready,
    input  logic [4*N-1:0] req_a,
    input  logic [4*N-1:0] req_b,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [1:0]     rsp_id,
    output logic [2*N-1:0] rsp_prod,
    output logic           busy,
    output logic [7:0]     op_count
);
    typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

    state_t         state;
    logic [1:0]     ptr;
    logic [N-1:0]   a_q, b_q;
    logic [1:0]     id_q;
    logic [2*N-1:0] prod_q;

    logic [1:0]     gnt, idx;
    logic           gnt_vld;
    logic [2*N-1:0] pp [N];
    logic [2*N-1:0] product;

    // Walk from the far end back to ptr so the nearest set bit at/after ptr wins.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req_valid[idx]) begin
                gnt     = idx;
                gnt_vld = 1'b1;
            end
        end
    end

    // Ready is gated by rst_n so nothing looks accepted while reset is held.
    assign req_ready = (rst_n && state == IDLE && gnt_vld) ? (4'b0001 << gnt) : 4'b0000;

    // Shift-and-add: one partial product per multiplier bit, summed at full width.
    for (genvar k = 0; k < N; k++) begin : g_pp
        assign pp[k] = b_q[k] ? ({{N{1'b0}}, a_q} << k) : '0;
    end

    always_comb begin
        product = '0;
        for (int k = 0; k < N; k++) product = product + pp[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= '0;
            prod_q   <= '0;
            op_count <= '0;
        end else begin
            case (state)
                IDLE: if (gnt_vld) begin
                    a_q   <= req_a[gnt*N +: N];
                    b_q   <= req_b[gnt*N +: N];
                    id_q  <= gnt;
                    ptr   <= gnt + 2'd1;
                    state <= MUL;
                end
                MUL: begin
                    prod_q <= product;
                    state  <= RESP;
                end
                RESP: if (rsp_ready) begin
                    op_count <= op_count + 8'd1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign rsp_id    = id_q;
    assign rsp_prod  = prod_q;
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter: inputs change and outputs are checked on the falling edge.
module tb_mul_share_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [3:0]     req_valid;
    logic [3:0]     req_ready;
    logic [4*N-1:0] req_a, req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [2*N-1:0] rsp_prod;
    logic           busy;
    logic [7:0]     op_count;

    int       vectors    = 0;
    int       miscompares = 0;
    logic [7:0] exp_cnt  = 8'd0;

    mul_share_arbiter #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_prod(rsp_prod),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
        req_a[i*N +: N] = a;
        req_b[i*N +: N] = b;
    endtask

    // Called in IDLE just before the accepting edge, with rsp_ready high.
    task automatic op(input string tag, input logic [3:0] er, input logic [1:0] eid,
                      input logic [7:0] ep);
        chk({tag, ".ready"}, 32'(req_ready), 32'(er));
        @(negedge clk);
        chk({tag, ".mul_busy"},  32'(busy), 32'd1);
        chk({tag, ".mul_vld"},   32'(rsp_valid), 32'd0);
        chk({tag, ".mul_ready"}, 32'(req_ready), 32'd0);
        @(negedge clk);
        chk({tag, ".rsp_vld"},   32'(rsp_valid), 32'd1);
        chk({tag, ".rsp_id"},    32'(rsp_id), 32'(eid));
        chk({tag, ".rsp_prod"},  32'(rsp_prod), 32'(ep));
        chk({tag, ".rsp_ready"}, 32'(req_ready), 32'd0);
        @(negedge clk);
        exp_cnt = exp_cnt + 8'd1;
        chk({tag, ".done_vld"},  32'(rsp_valid), 32'd0);
        chk({tag, ".done_busy"}, 32'(busy), 32'd0);
        chk({tag, ".op_count"},  32'(op_count), 32'(exp_cnt));
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 4'b1111; req_a = '0; req_b = '0; rsp_ready = 1'b1;

        // Reset state, with all requesters valid to prove ready is held off
        repeat (2) @(negedge clk);
        chk("rst.ready",    32'(req_ready), 32'd0);
        chk("rst.rsp_vld",  32'(rsp_valid), 32'd0);
        chk("rst.rsp_id",   32'(rsp_id), 32'd0);
        chk("rst.rsp_prod", 32'(rsp_prod), 32'd0);
        chk("rst.busy",     32'(busy), 32'd0);
        chk("rst.op_count", 32'(op_count), 32'd0);

        // Single request 15*15
        req_valid = 4'b0001; set_op(0, 4'hF, 4'hF);
        rst_n = 1'b1;
        #1;
        op("single", 4'b0001, 2'd0, 8'hE1);
        req_valid = 4'b0000;

        // Reset pulse in IDLE so round robin starts at requester 0
        rst_n = 1'b0; #1;
        chk("rst2.op_count", 32'(op_count), 32'd0);
        exp_cnt = 8'd0;
        @(negedge clk); rst_n = 1'b1;

        // All four held valid: a=i+1, b=3
        for (int i = 0; i < 4; i++) set_op(i, 4'(i + 1), 4'd3);
        req_valid = 4'b1111;
        #1;
        op("rr0", 4'b0001, 2'd0, 8'd3);
        op("rr1", 4'b0010, 2'd1, 8'd6);
        op("rr2", 4'b0100, 2'd2, 8'd9);
        op("rr3", 4'b1000, 2'd3, 8'd12);
        op("rr4", 4'b0001, 2'd0, 8'd3);
        req_valid = 4'b0000;

        // Backpressure: 5*6 held for 10 cycles with every requester valid
        set_op(0, 4'd5, 4'd6); req_valid = 4'b0001; rsp_ready = 1'b0;
        #1;
        chk("bp.ready", 32'(req_ready), 32'b0001);
        @(negedge clk);
        req_valid = 4'b1111;
        @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            chk("bp.vld",      32'(rsp_valid), 32'd1);
            chk("bp.prod",     32'(rsp_prod), 32'd30);
            chk("bp.id",       32'(rsp_id), 32'd0);
            chk("bp.ready0",   32'(req_ready), 32'd0);
            chk("bp.op_count", 32'(op_count), 32'(exp_cnt));
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        exp_cnt = exp_cnt + 8'd1;
        chk("bp.done_vld",  32'(rsp_valid), 32'd0);
        chk("bp.op_count",  32'(op_count), 32'(exp_cnt));
        req_valid = 4'b0000;

        // Operand change after accept: requester 1, 7*9
        set_op(1, 4'd7, 4'd9); req_valid = 4'b0010;
        #1;
        chk("chg.ready", 32'(req_ready), 32'b0010);
        @(negedge clk);
        req_a = '0; req_b = '0; req_valid = 4'b0000;
        @(negedge clk);
        chk("chg.vld",  32'(rsp_valid), 32'd1);
        chk("chg.prod", 32'(rsp_prod), 32'd63);
        chk("chg.id",   32'(rsp_id), 32'd1);
        @(negedge clk);
        exp_cnt = exp_cnt + 8'd1;
        chk("chg.op_count", 32'(op_count), 32'(exp_cnt));

        // Reset asserted while in RESP
        set_op(0, 4'd3, 4'd3); req_valid = 4'b0001;
        repeat (2) @(negedge clk);
        chk("rresp.vld_pre", 32'(rsp_valid), 32'd1);
        set_op(2, 4'd2, 4'd7); req_valid = 4'b1100;
        #2 rst_n = 1'b0;
        #1;
        chk("rresp.vld",      32'(rsp_valid), 32'd0);
        chk("rresp.op_count", 32'(op_count), 32'd0);
        chk("rresp.ready",    32'(req_ready), 32'd0);
        exp_cnt = 8'd0;
        @(negedge clk); rst_n = 1'b1;
        #1;
        op("rresp.first", 4'b0100, 2'd2, 8'd14);
        req_valid = 4'b0000;

        // Lone requester 0 until op_count wraps; edge operands cycle through
        req_valid = 4'b0001;
        for (int i = 0; i < 255; i++) begin
            case (i % 3)
                0: begin set_op(0, 4'd0, 4'd5); #1; op("wrap.a0", 4'b0001, 2'd0, 8'h00); end
                1: begin set_op(0, 4'd7, 4'd0); #1; op("wrap.b0", 4'b0001, 2'd0, 8'h00); end
                default: begin set_op(0, 4'h8, 4'h8); #1; op("wrap.88", 4'b0001, 2'd0, 8'h40); end
            endcase
        end
        req_valid = 4'b0000;
        chk("wrap.zero", 32'(op_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
